// File: rtl/return_address_stack_ckpt_pkg.sv
// return_address_stack_ckpt_pkg: shared defaults and checkpoint record for the return address stack.
package return_address_stack_ckpt_pkg;
  localparam int PHY_VIRT_MAX_ADDR_SIZE = 40;
  localparam int RAS_DEPTH = 16;
  localparam int RAS_NUM_CKPT = 4;
  localparam int RAS_HEAD_W = $clog2(RAS_DEPTH);
  typedef logic [PHY_VIRT_MAX_ADDR_SIZE-1:0] addrPC_t;
  typedef struct packed {
    logic [RAS_HEAD_W-1:0] head;
    logic [RAS_HEAD_W:0] count;
    addrPC_t top;
  } ras_ckpt_t;
  function automatic int idx_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/return_address_stack_ckpt_ckpt_table.sv
// ras_ckpt_table: NUM_CKPT checkpoint registers with one write port and one combinational read port.
module ras_ckpt_table
  import return_address_stack_ckpt_pkg::*;
#(
  parameter int NUM_CKPT = RAS_NUM_CKPT,
  parameter type ckpt_t = ras_ckpt_t,
  parameter int IW = idx_width(NUM_CKPT)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [IW-1:0] wid_i,
  input  ckpt_t         wdata_i,
  input  logic [IW-1:0] rid_i,
  output ckpt_t         rdata_o
);
  ckpt_t slot_q [NUM_CKPT];
  ckpt_t slot_d [NUM_CKPT];
  always_comb begin
    slot_d = slot_q;
    if (we_i) slot_d[wid_i] = wdata_i;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) slot_q <= '{default: '0};
    else slot_q <= slot_d;
  end
  assign rdata_o = slot_q[rid_i];
endmodule

// File: rtl/return_address_stack_ckpt.sv
// return_address_stack_ckpt: circular return address stack with one-cycle checkpoint restore.
// Define RAS_PERF_COUNTERS_EN to add 32-bit push/pop/overflow/underflow/restore event counters.
module return_address_stack_ckpt
  import return_address_stack_ckpt_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH,
  parameter int ADDR_WIDTH = PHY_VIRT_MAX_ADDR_SIZE,
  parameter int NUM_CKPT = RAS_NUM_CKPT,
  parameter int IW = idx_width(NUM_CKPT)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [ADDR_WIDTH-1:0] push_addr_i,
  input  logic                  ckpt_i,
  input  logic [IW-1:0]         ckpt_id_i,
  input  logic                  restore_i,
  input  logic [IW-1:0]         restore_id_i,
`ifdef RAS_PERF_COUNTERS_EN
  output logic [31:0]           push_cnt_o,
  output logic [31:0]           pop_cnt_o,
  output logic [31:0]           overflow_cnt_o,
  output logic [31:0]           underflow_cnt_o,
  output logic [31:0]           restore_cnt_o,
`endif
  output logic [ADDR_WIDTH-1:0] return_address_o,
  output logic                  valid_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);
  localparam int HW = $clog2(DEPTH);
  localparam int CW = HW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  typedef struct packed {
    logic [HW-1:0] head;
    logic [CW-1:0] count;
    logic [ADDR_WIDTH-1:0] top;
  } ckpt_t;
  logic [ADDR_WIDTH-1:0] entry_q [DEPTH];
  logic [ADDR_WIDTH-1:0] entry_d [DEPTH];
  logic [HW-1:0] head_q, head_d, top_idx, rst_idx;
  logic [CW-1:0] count_q, count_d;
  logic overflow_q, overflow_d, underflow_q, underflow_d;
  logic nonempty, push_ev, pop_ev;
  ckpt_t wr_ckpt, rd_ckpt;
  assign top_idx = head_q - 1'b1;
  assign rst_idx = rd_ckpt.head - 1'b1;
  assign nonempty = count_q != '0;
  assign wr_ckpt = '{head: head_q, count: count_q, top: entry_q[top_idx]};
  // Push/pop events as accepted this cycle; a replace-top counts as both, push+pop on empty as push only.
  assign push_ev = !restore_i && push_i;
  assign pop_ev = !restore_i && pop_i && nonempty;
  always_comb begin
    entry_d = entry_q;
    head_d = head_q;
    count_d = count_q;
    overflow_d = 1'b0;
    underflow_d = 1'b0;
    if (restore_i) begin
      head_d = rd_ckpt.head;
      count_d = rd_ckpt.count;
      if (rd_ckpt.count != '0) entry_d[rst_idx] = rd_ckpt.top;
    end else if (push_i && pop_i && nonempty) begin
      entry_d[top_idx] = push_addr_i;
    end else if (push_i) begin
      entry_d[head_q] = push_addr_i;
      head_d = head_q + 1'b1;
      overflow_d = count_q == FULL;
      count_d = count_q == FULL ? count_q : count_q + 1'b1;
    end else if (pop_i) begin
      underflow_d = !nonempty;
      head_d = nonempty ? top_idx : head_q;
      count_d = nonempty ? count_q - 1'b1 : count_q;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      entry_q <= '{default: '0};
      head_q <= '0;
      count_q <= '0;
      overflow_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      entry_q <= entry_d;
      head_q <= head_d;
      count_q <= count_d;
      overflow_q <= overflow_d;
      underflow_q <= underflow_d;
    end
  end
  ras_ckpt_table #(.NUM_CKPT(NUM_CKPT), .ckpt_t(ckpt_t), .IW(IW)) u_ckpt_table (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .we_i   (ckpt_i && !restore_i),
    .wid_i  (ckpt_id_i),
    .wdata_i(wr_ckpt),
    .rid_i  (restore_id_i),
    .rdata_o(rd_ckpt)
  );
  assign return_address_o = entry_q[top_idx];
  assign valid_o = nonempty;
  assign overflow_o = overflow_q;
  assign underflow_o = underflow_q;
`ifdef RAS_PERF_COUNTERS_EN
  logic [31:0] push_cnt_q, push_cnt_d, pop_cnt_q, pop_cnt_d, ovf_cnt_q, ovf_cnt_d;
  logic [31:0] unf_cnt_q, unf_cnt_d, rst_cnt_q, rst_cnt_d;
  always_comb begin
    push_cnt_d = push_cnt_q + {31'd0, push_ev};
    pop_cnt_d = pop_cnt_q + {31'd0, pop_ev};
    ovf_cnt_d = ovf_cnt_q + {31'd0, overflow_d};
    unf_cnt_d = unf_cnt_q + {31'd0, underflow_d};
    rst_cnt_d = rst_cnt_q + {31'd0, restore_i};
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      push_cnt_q <= '0;
      pop_cnt_q <= '0;
      ovf_cnt_q <= '0;
      unf_cnt_q <= '0;
      rst_cnt_q <= '0;
    end else begin
      push_cnt_q <= push_cnt_d;
      pop_cnt_q <= pop_cnt_d;
      ovf_cnt_q <= ovf_cnt_d;
      unf_cnt_q <= unf_cnt_d;
      rst_cnt_q <= rst_cnt_d;
    end
  end
  assign push_cnt_o = push_cnt_q;
  assign pop_cnt_o = pop_cnt_q;
  assign overflow_cnt_o = ovf_cnt_q;
  assign underflow_cnt_o = unf_cnt_q;
  assign restore_cnt_o = rst_cnt_q;
`else
  logic unused_ev;
  assign unused_ev = push_ev ^ pop_ev;
`endif
endmodule

// File: tb/tb_return_address_stack_ckpt.sv
// tb_return_address_stack_ckpt: directed-vector bench for the checkpointed return address stack.
module tb_return_address_stack_ckpt;
  logic clk = 1'b0;
  logic rst, push, pop, ckpt, restore;
  logic [39:0] addr;
  logic [1:0] ckpt_id, restore_id;
  logic [39:0] ra;
  logic valid, ovf, unf;
  int nv = 0;
  int nm = 0;
`ifdef RAS_PERF_COUNTERS_EN
  logic [31:0] push_cnt, pop_cnt, ovf_cnt, unf_cnt, rst_cnt;
`endif
  always #5 clk = ~clk;
  return_address_stack_ckpt dut (
    .clk_i(clk), .rst_i(rst), .push_i(push), .pop_i(pop), .push_addr_i(addr),
    .ckpt_i(ckpt), .ckpt_id_i(ckpt_id), .restore_i(restore), .restore_id_i(restore_id),
`ifdef RAS_PERF_COUNTERS_EN
    .push_cnt_o(push_cnt), .pop_cnt_o(pop_cnt), .overflow_cnt_o(ovf_cnt),
    .underflow_cnt_o(unf_cnt), .restore_cnt_o(rst_cnt),
`endif
    .return_address_o(ra), .valid_o(valid), .overflow_o(ovf), .underflow_o(unf)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nv++;
    assert (obs === exp) else begin
      nm++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input bit p, input bit q, input logic [39:0] a, input bit c,
                       input logic [1:0] cid, input bit r, input logic [1:0] rid);
    push = p; pop = q; addr = a; ckpt = c; ckpt_id = cid; restore = r; restore_id = rid;
    @(posedge clk);
    #1;
    push = 0; pop = 0; addr = '0; ckpt = 0; ckpt_id = '0; restore = 0; restore_id = '0;
  endtask
  task automatic do_push(input logic [39:0] a); drive(1, 0, a, 0, 0, 0, 0); endtask
  task automatic do_pop(); drive(0, 1, '0, 0, 0, 0, 0); endtask
  initial begin
    rst = 1; push = 0; pop = 0; addr = '0; ckpt = 0; ckpt_id = '0; restore = 0; restore_id = '0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("reset_ra", 64'(ra), 0);
    chk("reset_valid", 64'(valid), 0);
    chk("reset_ovf", 64'(ovf), 0);
    chk("reset_unf", 64'(unf), 0);
    do_push(40'h100); do_push(40'h200); do_push(40'h300);
    chk("push3_ra", 64'(ra), 64'h300);
    chk("push3_valid", 64'(valid), 1);
    do_pop(); chk("pop1_ra", 64'(ra), 64'h200);
    do_pop(); chk("pop2_ra", 64'(ra), 64'h100);
    do_pop(); chk("pop3_valid", 64'(valid), 0);
    chk("pop3_unf", 64'(unf), 0);
    do_pop();
    chk("empty_pop_unf", 64'(unf), 1);
    chk("empty_pop_valid", 64'(valid), 0);
    drive(0, 0, '0, 0, 0, 0, 0);
    chk("unf_one_cycle", 64'(unf), 0);
    do_push(40'h55); chk("after_unf_push_ra", 64'(ra), 64'h55);
    do_pop(); chk("after_unf_pop_valid", 64'(valid), 0);
    for (int i = 1; i <= 17; i++) begin
      do_push(40'(i));
      chk($sformatf("ovf_push%0d", i), 64'(ovf), (i == 17) ? 64'd1 : 64'd0);
    end
    chk("ovf_ra", 64'(ra), 64'h11);
    for (int k = 1; k <= 16; k++) begin
      do_pop();
      if (k < 16) chk($sformatf("drain_ra%0d", k), 64'(ra), 64'(17 - k));
      chk($sformatf("drain_valid%0d", k), 64'(valid), (k < 16) ? 64'd1 : 64'd0);
    end
    chk("drain_ovf_low", 64'(ovf), 0);
    do_push(40'h100); do_push(40'h200);
    drive(1, 1, 40'hABC, 0, 0, 0, 0);
    chk("rep_ra", 64'(ra), 64'hABC);
    do_pop(); chk("rep_pop_ra", 64'(ra), 64'h100);
    do_pop(); chk("rep_pop_valid", 64'(valid), 0);
    drive(1, 1, 40'hABC, 0, 0, 0, 0);
    chk("rep_empty_ra", 64'(ra), 64'hABC);
    chk("rep_empty_valid", 64'(valid), 1);
    chk("rep_empty_unf", 64'(unf), 0);
    do_pop(); chk("rep_empty_cnt1", 64'(valid), 0);
    do_push(40'h100); do_push(40'h200);
    drive(0, 0, '0, 1, 2'd2, 0, 0);
    drive(1, 1, 40'hDEAD, 0, 0, 0, 0);
    chk("wrong_path_ra", 64'(ra), 64'hDEAD);
    do_push(40'h300);
    chk("wrong_path_push_ra", 64'(ra), 64'h300);
    drive(0, 0, '0, 0, 0, 1, 2'd2);
    chk("restore_ra", 64'(ra), 64'h200);
    chk("restore_valid", 64'(valid), 1);
    do_pop(); chk("restore_pop_ra", 64'(ra), 64'h100);
    do_pop(); chk("restore_cnt2", 64'(valid), 0);
    do_push(40'h700);
    drive(0, 0, '0, 1, 2'd1, 0, 0);
    do_push(40'h800);
    drive(1, 0, 40'h999, 1, 2'd1, 1, 2'd1);
    chk("restore_push_ra", 64'(ra), 64'h700);
`ifdef RAS_PERF_COUNTERS_EN
    chk("restore_cnt_o", 64'(rst_cnt), 2);
`endif
    drive(0, 0, '0, 0, 0, 1, 2'd1);
    chk("ckpt_ignored_ra", 64'(ra), 64'h700);
    do_pop(); chk("ckpt_ignored_cnt1", 64'(valid), 0);
    do_push(40'h42);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    chk("midreset_valid", 64'(valid), 0);
    chk("midreset_ra", 64'(ra), 0);
    drive(0, 0, '0, 0, 0, 1, 2'd1);
    chk("midreset_ckpt_clear", 64'(valid), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nv, nm);
    $finish;
  end
endmodule
